// File: rtl/cei_mochila_pkg.sv
// ---------------------------------------------------------------------------
// cei_mochila_pkg
// System-level definitions for the cei_mochila SoC: the core arbiter state
// encoding, the default number of outstanding OBI transactions, and a helper
// that sizes port-index fields (at least one bit even for a single port).
// ---------------------------------------------------------------------------
package cei_mochila_pkg;

  // ARB_IDLE   : no request held toward the shared port, free to arbitrate
  // ARB_LOCKED : a request was presented but not granted; it must stay put
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned OBI_MAX_OUTSTANDING = 2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// ---------------------------------------------------------------------------
// obi_pkg
// Shared OBI request/response types used by cores, arbiters and the memory
// bus. Addresses and data are 32 bits wide with one byte enable per byte.
//   obi_req_t  : req, addr, we, be, wdata  (manager -> subordinate)
//   obi_resp_t : gnt, rvalid, rdata        (subordinate -> manager)
// ---------------------------------------------------------------------------
package obi_pkg;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;
  localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

  typedef struct packed {
    logic                  req;
    logic [OBI_ADDR_W-1:0] addr;
    logic                  we;
    logic [OBI_BE_W-1:0]   be;
    logic [OBI_DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_id_fifo.sv
// ---------------------------------------------------------------------------
// obi_id_fifo
// Small in-order FIFO holding the port index of every granted transaction
// that is still waiting for its response. The arbiter pushes on an accepted
// address handshake and pops on rvalid, so the head always names the port
// the next response belongs to.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push, push_data: enqueue one index (ignored when full)
//   pop            : dequeue the head (ignored when empty)
//   full, empty    : occupancy flags, derived from the registered count
//   head           : index at the front of the queue
// ---------------------------------------------------------------------------
module obi_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/obi_core_arbiter.sv
// ---------------------------------------------------------------------------
// obi_core_arbiter
// Round-robin arbiter that funnels NHARTS OBI manager ports onto a single
// shared subordinate port. A request is forwarded in the same cycle it is
// seen; once presented and not granted it is locked until granted so the
// address phase stays stable. Granted transactions are tracked by port index
// in an ID FIFO, and responses are routed back strictly in order.
// Parameters:
//   NHARTS          : number of requesting core ports
//   MAX_OUTSTANDING : granted-but-unanswered transactions allowed (1..8)
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   slv_req_i     : requests from each core port
//   slv_resp_o    : gnt / rvalid / rdata back to each core port
//   mst_req_o     : request toward the shared memory/bus port
//   mst_resp_i    : gnt / rvalid / rdata from the shared port
//   err_o         : sticky protocol-violation flag, cleared only by reset
// ---------------------------------------------------------------------------
module obi_core_arbiter
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int unsigned NHARTS          = 3,
  parameter int unsigned MAX_OUTSTANDING = OBI_MAX_OUTSTANDING
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  obi_req_t  [NHARTS-1:0] slv_req_i,
  output obi_resp_t [NHARTS-1:0] slv_resp_o,
  output obi_req_t               mst_req_o,
  input  obi_resp_t              mst_resp_i,
  output logic                   err_o
);

  localparam int unsigned IW = idx_width(NHARTS);

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic [IW-1:0] lock_q;
  logic [IW-1:0] lock_d;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] rr_d;
  logic          err_q;
  logic          err_d;

  logic [IW-1:0] cand;
  logic [IW-1:0] scan_idx;
  logic          found;
  logic [IW-1:0] winner;
  logic          present;
  logic          handshake;
  logic          resp_valid;

  logic          fifo_full;
  logic          fifo_empty;
  logic [IW-1:0] fifo_head;

  // Round-robin scan: first requesting port at or above rr_q, wrapping.
  always_comb begin
    found    = 1'b0;
    scan_idx = '0;
    cand     = '0;
    for (int i = 0; i < int'(NHARTS); i++) begin
      cand = IW'((int'(rr_q) + i) % NHARTS);
      if (!found && slv_req_i[cand].req) begin
        found    = 1'b1;
        scan_idx = cand;
      end
    end
  end

  // A locked port keeps the bus even if it illegally drops req. The request
  // is suppressed while the ID FIFO is full and while reset is asserted, so
  // every output reads zero during reset.
  assign winner     = (state_q == ARB_LOCKED) ? lock_q : scan_idx;
  assign present    = rst_ni && ((state_q == ARB_LOCKED) || found) && !fifo_full;
  assign handshake  = present && mst_resp_i.gnt;
  assign resp_valid = rst_ni && mst_resp_i.rvalid && !fifo_empty;

  // Forward the winning request and route gnt/rvalid back to single ports.
  always_comb begin
    mst_req_o  = '0;
    slv_resp_o = '0;
    if (present) begin
      mst_req_o             = slv_req_i[winner];
      mst_req_o.req         = 1'b1;
      slv_resp_o[winner].gnt = mst_resp_i.gnt;
    end
    if (resp_valid) begin
      slv_resp_o[fifo_head].rvalid = 1'b1;
      slv_resp_o[fifo_head].rdata  = mst_resp_i.rdata;
    end
  end

  // Next-state logic for the lock FSM, the round-robin pointer and err.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    err_d   = err_q;
    case (state_q)
      ARB_IDLE: begin
        if (present && !mst_resp_i.gnt) begin
          state_d = ARB_LOCKED;
          lock_d  = winner;
        end
      end
      ARB_LOCKED: begin
        if (handshake) begin
          state_d = ARB_IDLE;
        end
        if (!slv_req_i[lock_q].req) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    if (handshake) begin
      rr_d = (winner == IW'(NHARTS - 1)) ? '0 : winner + 1'b1;
    end
    if (mst_resp_i.rvalid && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (handshake),
    .push_data (winner),
    .pop       (resp_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

endmodule

// File: doc/obi_core_arbiter.md
OBI_CORE_ARBITER -- requirements
Module: obi_core_arbiter

Interface
REQ-001 Parameter NHARTS, default 3, number of requesting core ports.
REQ-002 Parameter MAX_OUTSTANDING, default 2, maximum granted-but-not-responded transactions; must be 1..8.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 slv_req_i  input  obi_req_t[NHARTS]  requests from core ports (req, addr, we, be, wdata).
REQ-006 slv_resp_o  output  obi_resp_t[NHARTS]  gnt, rvalid, rdata back to each core port.
REQ-007 mst_req_o  output  obi_req_t  single request toward the shared memory/bus port.
REQ-008 mst_resp_i  input  obi_resp_t  gnt, rvalid, rdata from the shared port.
REQ-009 err_o  output  1  sticky flag: protocol violation detected (rvalid with no outstanding transaction).

Function
REQ-010 States: IDLE (no request presented) and LOCKED (request presented to mst, not yet granted); lock_idx register holds the presented port.
REQ-011 IDLE: winner = first port with req=1 scanning from rr_ptr upward, modulo NHARTS; mst_req_o = winner's fields, mst_req_o.req=1, same cycle (zero-cycle request latency).
REQ-012 IDLE with winner and mst_resp_i.gnt=0 -> LOCKED, lock_idx=winner; LOCKED keeps forwarding port lock_idx regardless of other requests (OBI address-phase stability).
REQ-013 Handshake accepted when mst_req_o.req and mst_resp_i.gnt both 1; slv_resp_o[winner].gnt = mst_resp_i.gnt combinationally, all other gnt=0.
REQ-014 On accepted handshake: push winner index into ID FIFO; rr_ptr = (winner+1) mod NHARTS; state -> IDLE.
REQ-015 FIFO full (MAX_OUTSTANDING entries): mst_req_o.req=0, no gnt to any port; a pop in the same cycle does not unblock until next cycle.
REQ-016 mst_resp_i.rvalid with FIFO non-empty: slv_resp_o[head].rvalid=1, rdata routed from mst_resp_i.rdata same cycle, pop head; other ports rvalid=0.
REQ-017 Simultaneous push and pop in one cycle: both occur; occupancy unchanged.
REQ-018 rvalid with FIFO empty: response dropped, err_o set to 1 and held until reset.
REQ-019 Port deasserting req while LOCKED is an OBI violation: arbiter stays LOCKED, forwards current fields, sets err_o.
REQ-020 rdata to non-responding ports driven 0; mst_req_o fields driven 0 when req=0.
REQ-021 Responses in order; no reordering, no per-port buffering of rdata.

Reset
REQ-022 During and after reset: state=IDLE, rr_ptr=0, lock_idx=0, FIFO empty, err_o=0, all gnt/rvalid=0, mst_req_o all 0.
REQ-023 Reset asserted mid-transaction discards outstanding IDs; late rvalid after reset flags err_o.

Structure
REQ-024 Request/response structs come from obi_pkg; arbiter state enum and MAX_OUTSTANDING default belong in cei_mochila_pkg.
REQ-025 ID FIFO is sub-module obi_id_fifo (depth MAX_OUTSTANDING, width $clog2(NHARTS), push/pop/full/empty/head).
REQ-026 Arbiter plugs between cpu_system core_data ports and the shared memory bus; instruction ports use a second instance.

Verification
REQ-027 Ports 0,1,2 request simultaneously, slave grants every cycle -> grants in order 0,1,2 on consecutive cycles; rr_ptr returns to 0.
REQ-028 Port 1 requests addr 0x100, slave withholds gnt 3 cycles while port 0 requests -> port 1 stays forwarded, port 1 granted on cycle 4, port 0 next.
REQ-029 MAX_OUTSTANDING=2, two grants, no rvalid -> third request held with mst_req_o.req=0 until first rvalid, then granted next cycle.
REQ-030 Grants to ports 2 then 0, slave returns rdata 0xA5A5A5A5 then 0x5A5A5A5A -> port 2 gets 0xA5A5A5A5, port 0 gets 0x5A5A5A5A, in order.
REQ-031 rvalid injected with empty FIFO -> err_o=1 next cycle, no port rvalid; stays 1 until rst_ni low.
REQ-032 rst_ni pulsed low with 2 outstanding -> all outputs 0 asynchronously, FIFO empty, arbitration restarts at port 0.
